// File: rtl/imm_gen_stage_pkg.sv
// Shared opcodes, funct3 codes and immediate kind codes
// for the immediate-generation stage.
package imm_gen_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP_V   = 7'b1010111;

  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  typedef enum logic [3:0] {
    K_NONE    = 4'd0,
    K_I       = 4'd1,
    K_S       = 4'd2,
    K_B       = 4'd3,
    K_U       = 4'd4,
    K_J       = 4'd5,
    K_Z       = 4'd6,
    K_VSIMM5  = 4'd7,
    K_VZIMM11 = 4'd8,
    K_VIZIMM  = 4'd9
  } kind_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bundle between decode, the immediate
// stage and operand select.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [XLEN-1:0]  out_aux;
  logic [3:0]       out_kind;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_aux,
    output out_kind, out_tag
  );

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_aux,
    input  out_kind, out_tag
  );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate extraction for base and
// vector instruction formats.
module imm_decode_comb
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int VEXT_EN = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] aux,
  output kind_e           kind
);

  // Replicate bit w-1 of v into every higher bit.
  function automatic logic [XLEN-1:0] sx(
    input logic [31:0] v,
    input int          w
  );
    logic [XLEN-1:0] r;
    r = XLEN'(v);
    for (int b = 0; b < XLEN; b++) begin
      if (b >= w) r[b] = v[5'(w - 1)];
    end
    return r;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  // Select the immediate layout by opcode.
  always_comb begin
    imm  = '0;
    aux  = '0;
    kind = K_NONE;
    unique case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        kind = K_I;
        imm  = sx({20'b0, instr[31:20]}, 12);
      end
      OPC_SYSTEM: begin
        kind = K_Z;
        imm  = XLEN'(instr[19:15]);
      end
      OPC_STORE: begin
        kind = K_S;
        imm  = sx({20'b0, instr[31:25],
                   instr[11:7]}, 12);
      end
      OPC_BRANCH: begin
        kind = K_B;
        imm  = sx({19'b0, instr[31], instr[7],
                   instr[30:25], instr[11:8],
                   1'b0}, 13);
      end
      OPC_JAL: begin
        kind = K_J;
        imm  = sx({11'b0, instr[31],
                   instr[19:12], instr[20],
                   instr[30:21], 1'b0}, 21);
      end
      OPC_LUI, OPC_AUIPC: begin
        kind = K_U;
        imm  = sx({instr[31:12], 12'b0}, 32);
      end
      OPC_OP_V: begin
        if (VEXT_EN != 0) begin
          if (f3 == F3_OPIVI) begin
            kind = K_VSIMM5;
            imm  = sx({27'b0, instr[19:15]}, 5);
          end else if (f3 == F3_OPCFG) begin
            if (!instr[31]) begin
              kind = K_VZIMM11;
              imm  = XLEN'(instr[30:20]);
            end else if (instr[30]) begin
              kind = K_VIZIMM;
              imm  = XLEN'(instr[29:20]);
              aux  = XLEN'(instr[19:15]);
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage: decode, then a main
// register plus skid register behind valid/ready.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int VEXT_EN = 1,
  parameter int TAG_W   = 5
) (
  input logic      clock,
  input logic      reset,
  input logic      flush,
  imm_gen_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  aux;
    kind_e            kind;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_aux;
  kind_e           dec_kind;
  ent_t            dec;
  ent_t            main_q;
  ent_t            skid_q;
  logic            main_v;
  logic            skid_v;
  logic            in_xfer;
  logic            out_xfer;

  imm_decode_comb #(
    .XLEN    (XLEN),
    .VEXT_EN (VEXT_EN)
  ) u_dec (
    .instr (bus.in_instr),
    .imm   (dec_imm),
    .aux   (dec_aux),
    .kind  (dec_kind)
  );

  assign dec = '{imm:  dec_imm,
                 aux:  dec_aux,
                 kind: dec_kind,
                 tag:  bus.in_tag};

  assign bus.in_ready  = !skid_v;
  assign in_xfer       = bus.in_valid & !skid_v;
  assign out_xfer      = main_v & bus.out_ready;

  assign bus.out_valid = main_v;
  assign bus.out_imm   = main_q.imm;
  assign bus.out_aux   = main_q.aux;
  assign bus.out_kind  = main_q.kind;
  assign bus.out_tag   = main_q.tag;

  // Two-entry FIFO: skid only fills while main stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      if (in_xfer) begin
        main_v <= 1'b1;
        main_q <= dec;
      end
    end else if (out_xfer) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (in_xfer) begin
        main_q <= dec;
      end else begin
        main_v <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_v <= 1'b1;
      skid_q <= dec;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: three builds (RV32 vector, RV32
// base-only, RV64) driven with identical stimulus.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b1;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) bnv ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(5)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_instr  = in_instr;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;
  assign bnv.in_valid  = in_valid;
  assign bnv.in_instr  = in_instr;
  assign bnv.in_tag    = in_tag;
  assign bnv.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_instr  = in_instr;
  assign b64.in_tag    = in_tag;
  assign b64.out_ready = out_ready;

  imm_gen_stage #(.XLEN(32), .VEXT_EN(1), .TAG_W(5))
    dut32 (.clock(clk), .reset(rst),
           .flush(flush), .bus(b32));
  imm_gen_stage #(.XLEN(32), .VEXT_EN(0), .TAG_W(5))
    dutnv (.clock(clk), .reset(rst),
           .flush(flush), .bus(bnv));
  imm_gen_stage #(.XLEN(64), .VEXT_EN(1), .TAG_W(5))
    dut64 (.clock(clk), .reset(rst),
           .flush(flush), .bus(b64));

  task automatic chk(input string nm,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             nm, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One instruction through all three builds.
  task automatic vec(input string nm,
                     input logic [31:0] w,
                     input logic [4:0]  t,
                     input logic [63:0] i32,
                     input logic [63:0] a32,
                     input logic [3:0]  k,
                     input logic [63:0] i64,
                     input bit          is_v);
    in_valid = 1'b1;
    in_instr = w;
    in_tag   = t;
    cyc();
    in_valid = 1'b0;
    chk({nm, ".v"},   b32.out_valid, 1);
    chk({nm, ".tag"}, b32.out_tag, t);
    chk({nm, ".imm"}, b32.out_imm, i32);
    chk({nm, ".aux"}, b32.out_aux, a32);
    chk({nm, ".kind"}, b32.out_kind, k);
    chk({nm, ".imm64"}, b64.out_imm, i64);
    chk({nm, ".aux64"}, b64.out_aux, a32);
    chk({nm, ".kind64"}, b64.out_kind, k);
    chk({nm, ".nv.kind"}, bnv.out_kind,
        is_v ? 64'd0 : 64'(k));
    chk({nm, ".nv.imm"}, bnv.out_imm,
        is_v ? 64'd0 : i32);
    chk({nm, ".nv.aux"}, bnv.out_aux, 0);
  endtask

  logic [4:0] got[$];
  bit         acc;
  bit         seen;

  initial begin
    #12;
    chk("rst.out_valid", b32.out_valid, 0);
    chk("rst.out_imm", b32.out_imm, 0);
    chk("rst.out_aux", b32.out_aux, 0);
    chk("rst.out_kind", b32.out_kind, 0);
    chk("rst.out_tag", b32.out_tag, 0);
    chk("rst.out_imm64", b64.out_imm, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", b32.in_ready, 1);

    vec("addi", 32'hFFF00093, 5'd1, 64'hFFFFFFFF, 0,
        4'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    vec("sw", 32'hFE20AE23, 5'd2, 64'hFFFFFFFC, 0,
        4'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("lui", 32'h123452B7, 5'd3, 64'h12345000, 0,
        4'd4, 64'h12345000, 1'b0);
    vec("beq", 32'hFE000EE3, 5'd4, 64'hFFFFFFFC, 0,
        4'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("jal", 32'h008000EF, 5'd5, 64'h8, 0,
        4'd5, 64'h8, 1'b0);
    vec("csrwi", 32'h3002D073, 5'd6, 64'h5, 0,
        4'd6, 64'h5, 1'b0);
    vec("lui8", 32'h800000B7, 5'd7, 64'h80000000, 0,
        4'd4, 64'hFFFFFFFF80000000, 1'b0);
    vec("vaddvi", 32'h022EB0D7, 5'd8, 64'hFFFFFFFD, 0,
        4'd7, 64'hFFFFFFFFFFFFFFFD, 1'b1);
    vec("vsetivli", 32'hCD0470D7, 5'd9, 64'hD0, 64'h8,
        4'd9, 64'hD0, 1'b1);
    vec("vsetvli", 32'h0D0170D7, 5'd10, 64'hD0, 0,
        4'd8, 64'hD0, 1'b1);
    vec("vsetvl", 32'h800070D7, 5'd11, 0, 0,
        4'd0, 0, 1'b1);
    vec("add", 32'h002081B3, 5'd12, 0, 0,
        4'd0, 0, 1'b0);
    cyc();
    chk("idle.out_valid", b32.out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_tag    = 5'd1;
    chk("bp.ready0", b32.in_ready, 1);
    cyc();
    in_tag = 5'd2;
    chk("bp.ready1", b32.in_ready, 1);
    chk("bp.head1", b32.out_tag, 1);
    cyc();
    in_tag = 5'd3;
    chk("bp.ready2", b32.in_ready, 0);
    cyc();
    chk("bp.ready3", b32.in_ready, 0);
    chk("bp.head3", b32.out_tag, 1);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (b32.out_valid) got.push_back(b32.out_tag);
      acc = in_valid & b32.in_ready;
      cyc();
      if (acc) in_valid = 1'b0;
    end
    chk("bp.count", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("bp.order",
          (got.size() > k) ? got[k] : 5'h1f, k + 1);
    end

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd4;
    cyc();
    in_tag = 5'd5;
    cyc();
    chk("fl.full", b32.in_ready, 0);
    flush  = 1'b1;
    in_tag = 5'd6;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.out_valid", b32.out_valid, 0);
    chk("fl.in_ready", b32.in_ready, 1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (b32.out_valid) seen = 1'b1;
    end
    chk("fl.dropped", seen, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd8;
    cyc();
    chk("fl2.ready", b32.in_ready, 1);
    flush  = 1'b1;
    in_tag = 5'd9;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (b32.out_valid) seen = 1'b1;
      cyc();
    end
    chk("fl2.dropped", seen, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFE20AE23;
    in_tag    = 5'd10;
    cyc();
    in_valid = 1'b0;
    chk("ar.pre_valid", b32.out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar.out_valid", b32.out_valid, 0);
    chk("ar.out_imm", b32.out_imm, 0);
    chk("ar.out_aux", b32.out_aux, 0);
    chk("ar.out_kind", b32.out_kind, 0);
    chk("ar.out_tag", b32.out_tag, 0);
    chk("ar.out_imm64", b64.out_imm, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("ar.in_ready", b32.in_ready, 1);
    chk("ar.post_valid", b32.out_valid, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage between instruction fetch/decode and the operand-select logic of the RV32/RV64 core with the RVV extension. Extracts and extends the immediate directly from the raw instruction for base and vector formats. Adds the vector forms simm5, vsetvli zimm11, and the vsetivli zimm10 + uimm5 pair. Delivers the result through a valid/ready handshake with a 2-entry skid buffer, flush support and a pass-through tag.

Parameters:
XLEN, 32, datapath width; 32 or 64; all immediates are sign- or zero-extended to XLEN.
VEXT_EN, 1, 1 = decode OP-V immediates; 0 = OP-V yields kind NONE, imm 0.
TAG_W, 5, width of the opaque tag carried alongside each instruction (ROB/PC index).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous discard of all buffered entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction word
in_tag  in  TAG_W  tag accompanying in_instr
out_valid  out  1  out_* fields valid
out_ready  in  1  downstream accepts this cycle
out_imm  out  XLEN  primary immediate
out_aux  out  XLEN  secondary immediate (vsetivli uimm5, zero-extended), else 0
out_kind  out  4  immediate kind code
out_tag  out  TAG_W  tag of the presented entry

Behaviour:
- Reset (async, active-high): both buffer entries invalid; out_valid=0; out_imm, out_aux, out_kind, out_tag = 0; in_ready=1 on the first cycle after reset deasserts.
- Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N when the main entry is free.
- Buffering: main register plus one skid register. in_ready = !skid_valid, so in_ready does not depend combinationally on out_ready.
- Skid fill: if the main entry is held (out_valid & !out_ready) while an input transfers, the input goes to skid.
- Skid drain: on output transfer, skid moves to main. Order is strictly FIFO.
- Simultaneous in and out transfer with skid empty: main is replaced by the new entry.
- flush: both entries are invalidated at the next edge and any same-cycle input is dropped. flush has priority over all transfers.
- Decode is performed on in_instr before registering. opcode = instr[6:0].
  OP-IMM/LOAD/JALR: kind I, imm = sext(instr[31:20]).
  SYSTEM: kind Z, imm = zext(instr[19:15]).
  STORE: kind S, imm = sext({instr[31:25],instr[11:7]}).
  BRANCH: kind B, imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  JAL: kind J, imm = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  LUI/AUIPC: kind U, imm = sext({instr[31:12],12'b0}); sign-extension to 64 bits is required when XLEN=64.
  OP-V funct3=011 (OPIVI): kind VSIMM5, imm = sext(instr[19:15]).
  OP-V funct3=111 with instr[31]=0 (vsetvli): kind VZIMM11, imm = zext(instr[30:20]).
  OP-V funct3=111 with instr[31:30]=11 (vsetivli): kind VIZIMM, imm = zext(instr[29:20]), aux = zext(instr[19:15]).
  All other opcodes/funct3 values (incl. vsetvl, vector loads/stores, R-type): kind NONE, imm = aux = 0.
- out_aux = 0 for every kind except VIZIMM.

Decomposition:
- Add to constants.vh: the opcode defines (existing format defines plus OP-V 1010111 and funct3 OPIVI/OPCFG).
- Add to constants.vh: the kind codes NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6, VSIMM5=7, VZIMM11=8, VIZIMM=9.
- Sub-module imm_decode_comb (purely combinational, parametrised by XLEN/VEXT_EN) produces imm/aux/kind. imm_gen_stage holds the handshake and skid buffer.

Test Plan:
- Base decode (XLEN=32), out_ready=1:
  0xFFF00093 (addi -1) -> imm 0xFFFFFFFF, kind 1, one cycle after acceptance.
  0xFE20AE23 (sw -4) -> imm 0xFFFFFFFC, kind 2.
  0x123452B7 (lui) -> imm 0x12345000, kind 4.
- Vector decode:
  0x022EB0D7 (vadd.vi simm5=-3) -> imm 0xFFFFFFFD, kind 7, aux 0.
  A vsetivli with uimm5=8 and zimm10=0x0D0 -> imm 0x000000D0, aux 0x00000008, kind 9.
  With VEXT_EN=0, the same words -> kind 0, imm 0.
- Backpressure: out_ready=0 for 3 cycles while tags 1,2,3 are offered.
  Tags 1 and 2 are accepted; in_ready falls after the second acceptance.
  Release out_ready -> tags emerge 1, 2, 3 in order, no loss, no duplication.
- Flush with both entries full -> out_valid=0 and in_ready=1 after the next edge; a same-cycle input is never emitted.
- Reset asserted mid-stream with out_valid=1 -> out_valid=0 and all out_* = 0 immediately (asynchronous), without waiting for a clock edge.
- XLEN=64 build:
  0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF.
  lui 0x80000 -> imm 0xFFFFFFFF80000000.
